// File: rtl/vip1_mul_share_arb_if.sv
// vip1_mul_share_arb_if: per-requester operand channels plus the tagged result channel
interface vip1_mul_share_arb_if #(
    parameter int N_REQ = 4,
    parameter int ID_W = $clog2(N_REQ)
);
    logic [N_REQ-1:0] req_valid;
    logic [N_REQ-1:0] req_ready;
    logic [N_REQ*10-1:0] req_a;
    logic [N_REQ*12-1:0] req_b;
    logic res_valid;
    logic res_ready;
    logic [ID_W-1:0] res_id;
    logic [21:0] res_p;
    modport master (
        output req_valid, req_a, req_b, res_ready,
        input req_ready, res_valid, res_id, res_p
    );
    modport slave (
        input req_valid, req_a, req_b, res_ready,
        output req_ready, res_valid, res_id, res_p
    );
endinterface

// File: rtl/vip1_mul_share_arb.sv
// vip1_mul_share_arb: round-robin sharing of one 10x12 multiplier among N_REQ requesters
module vip1_mul_share_arb #(
    parameter int N_REQ = 4,
    parameter int PIPE_STAGES = 2,
    parameter int ID_W = $clog2(N_REQ)
) (
    input  logic ap_clk,
    input  logic ap_rst,
    vip1_mul_share_arb_if.slave bus,
    output logic [2:0] inflight
);
    logic en;
    logic xfer;
    logic deliver;
    logic [N_REQ-1:0] grant;
    logic [ID_W-1:0] last_gnt;
    logic [ID_W-1:0] gnt_id;
    logic [9:0] sel_a;
    logic [11:0] sel_b;
    logic s1_v;
    logic [ID_W-1:0] s1_id;
    logic [9:0] s1_a;
    logic [11:0] s1_b;
    logic sv [2:PIPE_STAGES];
    logic [ID_W-1:0] sid [2:PIPE_STAGES];
    logic [21:0] sp [2:PIPE_STAGES];

    assign en = ~bus.res_valid | bus.res_ready;
    assign bus.req_ready = (en & ~ap_rst) ? grant : '0;
    assign xfer = |(bus.req_valid & bus.req_ready);
    assign deliver = bus.res_valid & bus.res_ready;
    assign bus.res_valid = sv[PIPE_STAGES];
    assign bus.res_id = sid[PIPE_STAGES];
    assign bus.res_p = sp[PIPE_STAGES];

    // Two passes over constant indices: first those above last_gnt, then the wrap-around part
    always_comb begin
        logic found;
        found = 1'b0;
        grant = '0;
        gnt_id = '0;
        sel_a = '0;
        sel_b = '0;
        for (int j = 0; j < 2 * N_REQ; j++) begin
            if (!found && bus.req_valid[j % N_REQ] && ((j < N_REQ) == ((j % N_REQ) > int'(last_gnt)))) begin
                found = 1'b1;
                grant[j % N_REQ] = 1'b1;
                gnt_id = ID_W'(j % N_REQ);
                sel_a = bus.req_a[(j % N_REQ) * 10 +: 10];
                sel_b = bus.req_b[(j % N_REQ) * 12 +: 12];
            end
        end
    end

    // Pointer update, operand capture into stage 1 and in-flight accounting
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            last_gnt <= ID_W'(N_REQ - 1);
            s1_v <= 1'b0;
            s1_id <= '0;
            s1_a <= '0;
            s1_b <= '0;
            inflight <= '0;
        end else begin
            if (xfer) last_gnt <= gnt_id;
            if (en) begin
                s1_v <= xfer;
                s1_id <= gnt_id;
                s1_a <= sel_a;
                s1_b <= sel_b;
            end
            inflight <= inflight + {2'b0, xfer} - {2'b0, deliver};
        end
    end

    // Full-width product into stage 2, then plain carry stages; everything holds on stall
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            for (int s = 2; s <= PIPE_STAGES; s++) begin
                sv[s] <= 1'b0;
                sid[s] <= '0;
                sp[s] <= '0;
            end
        end else if (en) begin
            sv[2] <= s1_v;
            sid[2] <= s1_id;
            sp[2] <= {12'b0, s1_a} * {10'b0, s1_b};
            for (int s = 3; s <= PIPE_STAGES; s++) begin
                sv[s] <= sv[s-1];
                sid[s] <= sid[s-1];
                sp[s] <= sp[s-1];
            end
        end
    end
endmodule

// File: tb/tb_vip1_mul_share_arb.sv
// tb_vip1_mul_share_arb: scenario tasks plus a queue scoreboard for the shared multiplier arbiter
module tb_vip1_mul_share_arb;
    localparam int N = 4;
    localparam int P = 2;
    localparam int IW = 2;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [21:0] p;
    } res_t;

    logic ap_clk;
    logic ap_rst;
    logic [2:0] inflight;
    int checks;
    int passes;
    res_t q[$];
    logic [IW-1:0] m_last;
    logic [N-1:0] m_rdy;
    logic m_en;
    int mi;

    vip1_mul_share_arb_if #(.N_REQ(N), .ID_W(IW)) bus ();

    vip1_mul_share_arb #(.N_REQ(N), .PIPE_STAGES(P), .ID_W(IW)) dut (
        .ap_clk(ap_clk),
        .ap_rst(ap_rst),
        .bus(bus),
        .inflight(inflight)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    // Scoreboard: predicts grants, queues expected results, checks deliveries and in-flight count
    always @(negedge ap_clk) begin
        if (ap_rst) begin
            q.delete();
            m_last = IW'(N - 1);
        end else begin
            checks++;
            if (inflight !== 3'(q.size())) $display("FAIL sb_inflight got %0d exp %0d", inflight, q.size());
            else passes++;
            m_en = !bus.res_valid || bus.res_ready;
            m_rdy = '0;
            for (int k = 1; k <= N; k++) begin
                mi = (int'(m_last) + k) % N;
                if (m_en && m_rdy == '0 && bus.req_valid[mi]) m_rdy[mi] = 1'b1;
            end
            checks++;
            if (bus.req_ready !== m_rdy) $display("FAIL sb_ready got %b exp %b", bus.req_ready, m_rdy);
            else passes++;
            if (bus.res_valid === 1'b1) begin
                checks++;
                if (q.size() == 0) $display("FAIL sb_stale got id=%0d p=%0d exp no result", bus.res_id, bus.res_p);
                else if ({bus.res_id, bus.res_p} !== q[0]) $display("FAIL sb_result got id=%0d p=%0d exp id=%0d p=%0d", bus.res_id, bus.res_p, q[0].id, q[0].p);
                else passes++;
                if (bus.res_ready && q.size() > 0) void'(q.pop_front());
            end
            for (int i = 0; i < N; i++) begin
                if (m_rdy[i] && bus.req_valid[i]) begin
                    q.push_back('{id: IW'(i), p: {12'b0, bus.req_a[i*10 +: 10]} * {10'b0, bus.req_b[i*12 +: 12]}});
                    m_last = IW'(i);
                end
            end
        end
    end

    task automatic set_op(input int i, input logic [9:0] a, input logic [11:0] b);
        bus.req_a[i*10 +: 10] = a;
        bus.req_b[i*12 +: 12] = b;
    endtask

    task automatic do_reset();
        ap_rst = 1'b1;
        bus.req_valid = '0;
        bus.res_ready = 1'b1;
        repeat (2) @(posedge ap_clk);
        #1 ap_rst = 1'b0;
    endtask

    task automatic drain();
        bus.req_valid = '0;
        repeat (P + 2) @(posedge ap_clk);
        #1;
        checks++;
        if (q.size() != 0 || bus.res_valid !== 1'b0 || inflight !== 3'd0)
            $display("FAIL drain got q=%0d res_valid=%b inflight=%0d exp 0 0 0", q.size(), bus.res_valid, inflight);
        else passes++;
    endtask

    task automatic test_reset();
        ap_rst = 1'b1;
        bus.req_valid = '1;
        bus.res_ready = 1'b1;
        repeat (2) @(posedge ap_clk);
        #1;
        checks++;
        if (bus.res_valid !== 1'b0 || inflight !== 3'd0 || bus.req_ready !== 4'b0000)
            $display("FAIL reset_state got res_valid=%b inflight=%0d ready=%b exp 0 0 0000", bus.res_valid, inflight, bus.req_ready);
        else passes++;
        checks++;
        if (bus.res_p !== 22'd0 || bus.res_id !== 2'd0) $display("FAIL reset_data got id=%0d p=%0d exp 0 0", bus.res_id, bus.res_p);
        else passes++;
        ap_rst = 1'b0;
        bus.req_valid = 4'b0100;
        set_op(2, 10'd1023, 12'd4095);
        @(negedge ap_clk);
        checks++;
        if (bus.req_ready !== 4'b0100 || inflight !== 3'd0) $display("FAIL first_ready got ready=%b inflight=%0d exp 0100 0", bus.req_ready, inflight);
        else passes++;
        @(posedge ap_clk);
        #1 bus.req_valid = '0;
        repeat (P - 1) begin
            @(negedge ap_clk);
            checks++;
            if (bus.res_valid !== 1'b0 || inflight !== 3'd1) $display("FAIL latency_early got res_valid=%b inflight=%0d exp 0 1", bus.res_valid, inflight);
            else passes++;
            @(posedge ap_clk);
        end
        @(negedge ap_clk);
        checks++;
        if (bus.res_valid !== 1'b1 || bus.res_id !== 2'd2 || bus.res_p !== 22'd4189185 || inflight !== 3'd1)
            $display("FAIL latency_result got v=%b id=%0d p=%0d inflight=%0d exp 1 2 4189185 1", bus.res_valid, bus.res_id, bus.res_p, inflight);
        else passes++;
        @(posedge ap_clk);
        @(negedge ap_clk);
        checks++;
        if (bus.res_valid !== 1'b0 || inflight !== 3'd0) $display("FAIL after_deliver got res_valid=%b inflight=%0d exp 0 0", bus.res_valid, inflight);
        else passes++;
        @(posedge ap_clk);
        #1;
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp;
        do_reset();
        for (int i = 0; i < N; i++) set_op(i, 10'(i + 1), 12'd10);
        bus.req_valid = '1;
        for (int k = 0; k < 12; k++) begin
            @(negedge ap_clk);
            exp = '0;
            exp[k % N] = 1'b1;
            checks++;
            if (bus.req_ready !== exp) $display("FAIL rr_grant got %b exp %b", bus.req_ready, exp);
            else passes++;
            if (k >= P) begin
                checks++;
                if (bus.res_valid !== 1'b1 || bus.res_id !== IW'((k - P) % N) || bus.res_p !== 22'(((k - P) % N + 1) * 10))
                    $display("FAIL rr_result got v=%b id=%0d p=%0d exp 1 %0d %0d", bus.res_valid, bus.res_id, bus.res_p, (k - P) % N, ((k - P) % N + 1) * 10);
                else passes++;
            end
            @(posedge ap_clk);
            #1;
        end
        drain();
    endtask

    task automatic test_alternate();
        do_reset();
        set_op(1, 10'd5, 12'd6);
        set_op(3, 10'd7, 12'd8);
        bus.req_valid = 4'b0010;
        @(posedge ap_clk);
        #1 bus.req_valid = 4'b1010;
        for (int k = 0; k < 8; k++) begin
            @(negedge ap_clk);
            checks++;
            if (bus.req_ready !== ((k % 2 == 0) ? 4'b1000 : 4'b0010))
                $display("FAIL alt_grant got %b exp %b", bus.req_ready, (k % 2 == 0) ? 4'b1000 : 4'b0010);
            else passes++;
            checks++;
            if ((bus.req_ready[0] | bus.req_ready[2]) !== 1'b0) $display("FAIL alt_idle got %b exp 0", bus.req_ready[0] | bus.req_ready[2]);
            else passes++;
            @(posedge ap_clk);
            #1;
        end
        drain();
    endtask

    task automatic test_stall();
        for (int i = 0; i < N; i++) set_op(i, 10'(100 + i * 200), 12'(7 + i * 1000));
        bus.req_valid = '1;
        bus.res_ready = 1'b1;
        repeat (P + 2) @(posedge ap_clk);
        #1 bus.res_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge ap_clk);
            checks++;
            if (bus.req_ready !== 4'b0000 || bus.res_valid !== 1'b1) $display("FAIL stall_hold got ready=%b v=%b exp 0000 1", bus.req_ready, bus.res_valid);
            else passes++;
            checks++;
            if (q.size() == 0) $display("FAIL stall_data got empty queue exp pending result");
            else if ({bus.res_id, bus.res_p} !== q[0]) $display("FAIL stall_data got id=%0d p=%0d exp id=%0d p=%0d", bus.res_id, bus.res_p, q[0].id, q[0].p);
            else passes++;
            checks++;
            if (inflight !== 3'(P)) $display("FAIL stall_inflight got %0d exp %0d", inflight, P);
            else passes++;
            @(posedge ap_clk);
            #1;
        end
        bus.res_ready = 1'b1;
        repeat (3) @(posedge ap_clk);
        #1;
        drain();
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < N; i++) set_op(i, 10'(i + 3), 12'(i + 9));
        bus.req_valid = 4'b0001;
        @(posedge ap_clk);
        #1 bus.req_valid = 4'b0010;
        @(posedge ap_clk);
        #1 bus.req_valid = '1;
        checks++;
        if (inflight !== 3'd2) $display("FAIL arst_pre got inflight=%0d exp 2", inflight);
        else passes++;
        #2 ap_rst = 1'b1;
        #1;
        checks++;
        if (bus.res_valid !== 1'b0 || inflight !== 3'd0 || bus.req_ready !== 4'b0000)
            $display("FAIL arst_drop got v=%b inflight=%0d ready=%b exp 0 0 0000", bus.res_valid, inflight, bus.req_ready);
        else passes++;
        repeat (2) @(posedge ap_clk);
        #1 ap_rst = 1'b0;
        @(negedge ap_clk);
        checks++;
        if (bus.req_ready !== 4'b0001) $display("FAIL arst_first got %b exp 0001", bus.req_ready);
        else passes++;
        @(posedge ap_clk);
        #1;
        drain();
    endtask

    task automatic test_edge_operands();
        logic [9:0] ea [3] = '{10'd0, 10'd1023, 10'd1};
        logic [11:0] eb [3] = '{12'd4095, 12'd0, 12'd1};
        logic [21:0] ep [3] = '{22'd0, 22'd0, 22'd1};
        bus.req_valid = 4'b0001;
        set_op(0, ea[0], eb[0]);
        for (int k = 0; k < 3 + P; k++) begin
            @(negedge ap_clk);
            if (k < 3) begin
                checks++;
                if (bus.req_ready !== 4'b0001) $display("FAIL edge_ready got %b exp 0001", bus.req_ready);
                else passes++;
            end
            if (k >= P) begin
                checks++;
                if (bus.res_valid !== 1'b1 || bus.res_id !== 2'd0 || bus.res_p !== ep[k-P])
                    $display("FAIL edge_product got v=%b id=%0d p=%0d exp 1 0 %0d", bus.res_valid, bus.res_id, bus.res_p, ep[k-P]);
                else passes++;
            end
            @(posedge ap_clk);
            #1;
            if (k + 1 < 3) set_op(0, ea[k+1], eb[k+1]);
            else bus.req_valid = '0;
        end
        drain();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1);
    end

    initial begin
        checks = 0;
        passes = 0;
        ap_rst = 1'b1;
        bus.req_valid = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.res_ready = 1'b1;
        test_reset();
        test_round_robin();
        test_alternate();
        test_stall();
        test_async_reset();
        test_edge_operands();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
